// File: rtl/sum_mul_seq.sv
// sum_mul_seq: unsigned shift-and-add multiplier controller.
// One add/shift iteration is performed per clock using an external w-bit
// ripple adder (sum_block). The adder has no carry-out, so the carry is
// reconstructed here from the operand and sum MSBs.
module sum_mul_seq #(
  parameter int w = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [w-1:0]   a,
  input  logic [w-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*w-1:0] product,
  output logic [w-1:0]   add_x,
  output logic [w-1:0]   add_y,
  output logic           add_cin,
  input  logic [w-1:0]   add_sum
);

  localparam int CW = $clog2(w) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [w-1:0]  mcand;
  logic [w-1:0]  ph;
  logic [w-1:0]  pl;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          last_iter;
  logic          accept;

  // Adder operands: accumulator high half plus multiplicand when the
  // current multiplier bit is set; carry-in is never used.
  always_comb begin
    add_x   = ph;
    add_y   = pl[0] ? mcand : '0;
    add_cin = 1'b0;
  end

  // Rebuild the adder carry-out: a carry leaves the MSB if both MSBs are
  // set, or if one is set and the sum MSB came out clear.
  always_comb begin
    carry = (add_x[w-1] & add_y[w-1]) |
            ((add_x[w-1] | add_y[w-1]) & ~add_sum[w-1]);
  end

  // Status and handshake decode from the registered state.
  always_comb begin
    busy      = (state == CALC);
    done      = (state == DONE);
    product   = {ph, pl};
    last_iter = (cnt == CW'(w - 1));
    accept    = start && ((state == IDLE) || (state == DONE));
  end

  // Controller and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mcand <= '0;
      ph    <= '0;
      pl    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand <= a;
            pl    <= b;
            ph    <= '0;
            cnt   <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          {ph, pl} <= {carry, add_sum, pl[w-1:1]};
          cnt      <= cnt + 1'b1;
          if (last_iter) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
